// File: rtl/mem_lb_pkg.sv
// Shared local-bus widths and the read-path FSM state encoding.
package mem_lb_pkg;
  localparam int LB_ADR_W  = 32;
  localparam int SYS_LEN_W = 20;
  localparam int MEM_LEN_W = 8;
  localparam int SYS_DW    = 256;
  localparam int MEM_DW    = 512;

  typedef enum logic [2:0] {IDLE, CHK, ISSUE, NEXT, DRAIN, END} state_t;
endpackage

// File: rtl/sync_fifo_bram.sv
// Single-clock FIFO with a registered read port; the array itself carries no reset.
module sync_fifo_bram #(
  parameter int DW    = 512,
  parameter int DEPTH = 256
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  assign ovf   = wr_en & full;

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/mem_rd_sync_256b.sv
// SYS read request -> reserved MEM 512b bursts -> buffered -> 256b words to SYS, low half first.
module mem_rd_sync_256b
  import mem_lb_pkg::*;
#(
  parameter int P_MEM_LB_LEN = 128
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 SYS_LB_REQ,
  input  logic [LB_ADR_W-1:0]  SYS_LB_ADR,
  input  logic [SYS_LEN_W-1:0] SYS_LB_LEN,
  output logic                 SYS_LB_ACK,
  output logic                 SYS_LB_WVLD,
  input  logic                 SYS_LB_WRDY,
  output logic [SYS_DW-1:0]    SYS_LB_WDAT,
  output logic                 MEM_LB_REQ,
  output logic [LB_ADR_W-1:0]  MEM_LB_ADR,
  output logic [MEM_LEN_W-1:0] MEM_LB_LEN,
  input  logic                 MEM_LB_ACK,
  input  logic                 MEM_LB_WREN,
  input  logic                 MEM_LB_WEND,
  input  logic [MEM_DW-1:0]    MEM_LB_WDAT,
  output logic                 ERR_OVF
);
  localparam int DEPTH = 2 * P_MEM_LB_LEN;
  localparam int RSV_W = $clog2(DEPTH) + 1;
  localparam int REM_W = SYS_LEN_W - 1;
  localparam logic [MEM_LEN_W-1:0] P_LEN   = MEM_LEN_W'(P_MEM_LB_LEN);
  localparam logic [RSV_W:0]       RSV_MAX = (RSV_W+1)'(DEPTH);

  state_t               state, state_nxt;
  logic [REM_W-1:0]     rem_beats;
  logic [LB_ADR_W-1:0]  adr;
  logic [MEM_LEN_W-1:0] beats;
  logic [RSV_W-1:0]     rsv_cnt;
  logic                 fits, burst_acc;

  logic [MEM_DW-1:0]    fifo_dout;
  logic                 fifo_full, fifo_empty, fifo_ovf, rd_en;
  logic                 ovld, hi, sys_acc, hi_acc;
  logic                 unused_ok;

  assign unused_ok = &{1'b0, MEM_LB_WEND, SYS_LB_LEN[0], fifo_full};

  assign beats     = (rem_beats > REM_W'(P_MEM_LB_LEN)) ? P_LEN : rem_beats[MEM_LEN_W-1:0];
  assign fits      = ({1'b0, rsv_cnt} + (RSV_W+1)'(beats)) <= RSV_MAX;
  assign burst_acc = (state == ISSUE) & MEM_LB_ACK;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (SYS_LB_REQ) state_nxt = CHK;
      CHK:     if (rem_beats == '0) state_nxt = DRAIN;
               else if (fits)       state_nxt = ISSUE;
      ISSUE:   if (MEM_LB_ACK) state_nxt = NEXT;
      NEXT:    state_nxt = CHK;
      DRAIN:   if (rsv_cnt == '0 && !ovld) state_nxt = END;
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      rem_beats <= '0;
      adr       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && SYS_LB_REQ) begin
        rem_beats <= SYS_LB_LEN[SYS_LEN_W-1:1];
        adr       <= SYS_LB_ADR;
      end else if (state == NEXT) begin
        rem_beats <= rem_beats - REM_W'(beats);
        adr       <= adr + LB_ADR_W'({beats, 6'b0});
      end
    end
  end

  // Reservation covers outstanding beats plus every entry not yet fully handed to SYS.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rsv_cnt <= '0;
    else        rsv_cnt <= rsv_cnt + (burst_acc ? RSV_W'(beats) : '0) - RSV_W'(hi_acc);
  end

  sync_fifo_bram #(.DW(MEM_DW), .DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (MEM_LB_WREN),
    .wr_data (MEM_LB_WDAT),
    .rd_en   (rd_en),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ovf     (fifo_ovf)
  );

  // The FIFO read register doubles as the holding register; it only advances after the high half leaves.
  assign sys_acc = ovld & SYS_LB_WRDY;
  assign hi_acc  = sys_acc & hi;
  assign rd_en   = ~fifo_empty & (~ovld | hi_acc);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovld    <= 1'b0;
      hi      <= 1'b0;
      ERR_OVF <= 1'b0;
    end else begin
      if (rd_en) begin
        ovld <= 1'b1;
        hi   <= 1'b0;
      end else if (hi_acc) begin
        ovld <= 1'b0;
        hi   <= 1'b0;
      end else if (sys_acc) begin
        hi   <= 1'b1;
      end
      if (fifo_ovf) ERR_OVF <= 1'b1;
    end
  end

  assign SYS_LB_WVLD = ovld;
  assign SYS_LB_WDAT = hi ? fifo_dout[MEM_DW-1:SYS_DW] : fifo_dout[SYS_DW-1:0];
  assign SYS_LB_ACK  = (state == END);
  assign MEM_LB_REQ  = (state == ISSUE);
  assign MEM_LB_ADR  = MEM_LB_REQ ? adr : '0;
  assign MEM_LB_LEN  = MEM_LB_REQ ? beats : '0;
endmodule
